uart_tx_buffer: RTL and testbench

- Byte FIFO plus handshake FSM that sits directly upstream of UART_Top's transmit side.
- Accepts bytes from a host or core write port, stores them, and feeds UART_Top one at a time through din_tx/data_update.
- Advances to the next byte only after UART_Top reports done_tx, so back-to-back frames go out without host pacing.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_buffer_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_buffer.sv | 136 +++++++++++++
 tb/tb_uart_tx_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit buffer: FSM states, byte
// width and default FIFO depth / inter-frame gap / frame timeout.
package uart_pkg;

  localparam int UART_DATA_W            = 8;
  localparam int DEFAULT_DEPTH          = 16;
  localparam int DEFAULT_GAP_CYCLES     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 20000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Circular byte FIFO with registered occupancy. A push while full is only
// accepted when a pop frees an entry in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus handshake FSM feeding UART_Top's transmit side one frame at a time.
// Optional frame timeout and timeout_err port: define UART_TX_BUFFER_TIMEOUT_EN.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [UART_DATA_W-1:0] din_tx,
  output logic                   data_update,
  input  logic                   done_tx,
  output logic                   busy
`ifdef UART_TX_BUFFER_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("uart_tx_buffer: illegal DEPTH, GAP_CYCLES or TIMEOUT_CYCLES");
  end

  tx_state_e              state_q;
  logic [UART_DATA_W-1:0] din_q;
  logic                   dup_q;
  logic [GAP_W-1:0]       gap_q;
  logic                   done_q;
  logic                   overflow_q;
  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   pop;
  logic                   done_rise;
  logic                   timeout_hit;

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(UART_DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (wr_en),
    .pop_i    (pop),
    .wr_data_i(wr_data),
    .rd_data_o(fifo_rd_data),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (count)
  );

  assign pop         = (state_q == LOAD);
  assign done_rise   = done_tx & ~done_q;
  assign din_tx      = din_q;
  assign data_update = dup_q;
  assign busy        = (state_q != IDLE);
  assign overflow    = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= done_tx;
      if (wr_en && full && !pop) overflow_q <= 1'b1;
    end
  end

`ifdef UART_TX_BUFFER_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMR_W-1:0] tmr_q;
  logic             timeout_err_q;

  assign timeout_hit = (state_q == SEND) && !done_rise &&
                       (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;

  // Frame timer only advances while a frame is waiting for done_tx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == SEND && !done_rise && !timeout_hit) tmr_q <= tmr_q + 1'b1;
      else                                               tmr_q <= '0;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // A timed-out frame leaves through the same GAP path as a completed one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      din_q   <= '0;
      dup_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) state_q <= LOAD;
        end
        LOAD: begin
          din_q   <= fifo_rd_data;
          dup_q   <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (done_rise || timeout_hit) begin
            dup_q   <= 1'b0;
            gap_q   <= GAP_W'(GAP_CYCLES - 1);
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q == '0) state_q <= IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized and directed bench for uart_tx_buffer against a queue/timestamp model.
// Define UART_TX_BUFFER_TIMEOUT_EN to also exercise the frame timeout.
module tb_uart_tx_buffer;

  localparam int DEPTH   = 16;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 100;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrEn;
  logic [7:0]    wrData;
  logic          doneTx;
  logic          full, empty, overflow, dataUpdate, busy;
  logic [CW-1:0] count;
  logic [7:0]    dinTx;
`ifdef UART_TX_BUFFER_TIMEOUT_EN
  logic          timeoutErr;
`endif

  always #5 clk = ~clk;

  uart_tx_buffer #(
    .DEPTH         (DEPTH),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wrEn),
    .wr_data    (wrData),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .din_tx     (dinTx),
    .data_update(dataUpdate),
    .done_tx    (doneTx),
    .busy       (busy)
`ifdef UART_TX_BUFFER_TIMEOUT_EN
    ,
    .timeout_err(timeoutErr)
`endif
  );

  // Reference model: a byte queue plus timestamps of when the line is free again.
  logic [7:0] mq[$];
  logic [7:0] mDin;
  bit         mLoading, mActive, mOvf, mTerr, mPrevDone;
  int         mIdleFrom, mStart, mCyc;

  int         vectors = 0;
  int         misses  = 0;
  logic [7:0] seenBytes[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mDin      = 8'h00;
    mLoading  = 1'b0;
    mActive   = 1'b0;
    mOvf      = 1'b0;
    mTerr     = 1'b0;
    mPrevDone = 1'b0;
    mIdleFrom = mCyc;
    mStart    = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep();
    bit rise, wasActive, popNow;
    int preSize;
    rise      = doneTx && !mPrevDone;
    mPrevDone = doneTx;
    preSize   = mq.size();
    wasActive = mActive;
    popNow    = mLoading;
    if (mActive) begin
      if (rise) begin
        mActive   = 1'b0;
        mIdleFrom = mCyc + GAP + 1;
      end
`ifdef UART_TX_BUFFER_TIMEOUT_EN
      else if (mCyc - mStart == TIMEOUT) begin
        mActive   = 1'b0;
        mTerr     = 1'b1;
        mIdleFrom = mCyc + GAP + 1;
      end
`endif
    end
    if (popNow) begin
      mDin     = mq.pop_front();
      mActive  = 1'b1;
      mLoading = 1'b0;
      mStart   = mCyc;
    end else if (!wasActive && !mLoading && mCyc >= mIdleFrom && preSize > 0) begin
      mLoading = 1'b1;
    end
    if (wrEn) begin
      if (preSize < DEPTH || popNow) mq.push_back(wrData);
      else                           mOvf = 1'b1;
    end
    mCyc++;
  endtask

  task automatic checkState();
    checkOutput("count", 32'(count), 32'(mq.size()));
    checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
    checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
    checkOutput("din_tx", 32'(dinTx), 32'(mDin));
    checkOutput("data_update", 32'(dataUpdate), 32'(mActive));
    checkOutput("busy", 32'(busy), 32'(mLoading || mActive || (mCyc < mIdleFrom)));
`ifdef UART_TX_BUFFER_TIMEOUT_EN
    checkOutput("timeout_err", 32'(timeoutErr), 32'(mTerr));
`endif
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic dn);
    @(negedge clk);
    wrEn   = w;
    wrData = d;
    doneTx = dn;
    @(posedge clk);
    modelStep();
    #1;
    checkState();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst    = 1'b1;
    wrEn   = 1'b0;
    wrData = 8'h00;
    doneTx = 1'b0;
    #1;
    modelReset();
    checkState();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitDataUpdate(input string tag);
    int n = 0;
    while (!dataUpdate && n < 16) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      n++;
    end
    checkOutput(tag, 32'(dataUpdate), 32'd1);
  endtask

  // Pulse done_tx periodically and log every byte offered to the transmitter.
  task automatic drainAndCollect(input int maxCycles);
    logic prevDu = 1'b0;
    seenBytes.delete();
    for (int i = 0; i < maxCycles; i++) begin
      if (dataUpdate && !prevDu) seenBytes.push_back(dinTx);
      prevDu = dataUpdate;
      if (!busy && empty) break;
      applyStimulus(1'b0, 8'h00, (i % 4) == 3);
    end
    checkOutput("drain_done", 32'(!busy && empty), 32'd1);
  endtask

  task automatic randomPhase(input int cycles, input int pWr, input int pDone);
    for (int i = 0; i < cycles; i++)
      applyStimulus($urandom_range(0, 99) < pWr, 8'($urandom), $urandom_range(0, 99) < pDone);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, gapCnt, peak, starts, hiCnt, stale;
    logic prevDu;

    rst    = 1'b1;
    wrEn   = 1'b0;
    wrData = 8'h00;
    doneTx = 1'b0;
    mCyc   = 0;
    #12;
    modelReset();
    checkState();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] single byte latency and gap");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    lat = 1;
    while (!dataUpdate && lat < 10) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'd3);
    checkOutput("first_din", 32'(dinTx), 32'h A5);
    applyStimulus(1'b0, 8'h00, 1'b1);
    gapCnt = 0;
    while (busy && gapCnt < 20) begin
      gapCnt++;
      applyStimulus(1'b0, 8'h00, 1'b0);
    end
    checkOutput("gap_len", 32'(gapCnt), 32'(GAP));
    checkOutput("empty_after", 32'(empty), 32'd1);

    $display("[TB] burst order");
    doReset();
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      if (int'(count) > peak) peak = int'(count);
    end
    checkOutput("burst_peak", 32'(peak), 32'd4);
    drainAndCollect(200);
    checkOutput("burst_n", 32'(seenBytes.size()), 32'd5);
    for (int i = 0; i < seenBytes.size() && i < 5; i++)
      checkOutput("burst_byte", 32'(seenBytes[i]), 32'(i + 1));

    $display("[TB] full, overflow, write during pop");
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_count", 32'(count), 32'd16);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0);
    checkOutput("simul_count", 32'(count), 32'd16);
    checkOutput("simul_din", 32'(dinTx), 32'h41);
    drainAndCollect(600);
    checkOutput("full_n", 32'(seenBytes.size()), 32'd17);
    for (int i = 0; i < seenBytes.size() && i < 16; i++)
      checkOutput("full_byte", 32'(seenBytes[i]), 32'(8'h41 + i));
    if (seenBytes.size() == 17) checkOutput("simul_byte", 32'(seenBytes[16]), 32'h C3);

    $display("[TB] held done_tx");
    doReset();
    applyStimulus(1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0);
    waitDataUpdate("held_wait");
    starts = 0;
    prevDu = dataUpdate;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (dataUpdate && !prevDu) starts++;
      prevDu = dataUpdate;
    end
    checkOutput("held_starts", 32'(starts), 32'd1);
    checkOutput("held_din", 32'(dinTx), 32'h BB);
    checkOutput("held_du", 32'(dataUpdate), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("held_release", 32'(dataUpdate), 32'd0);

    $display("[TB] random traffic");
    doReset();
    randomPhase(300, 30, 20);
    randomPhase(300, 70, 5);
    randomPhase(300, 10, 60);

    $display("[TB] reset mid-frame");
    doReset();
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b1, 8'h6B, 1'b0);
    waitDataUpdate("rst_wait");
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_du", 32'(dataUpdate), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_din", 32'(dinTx), 32'd0);
    modelReset();
    checkState();
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (dataUpdate || busy) stale++;
    end
    checkOutput("no_stale", 32'(stale), 32'd0);

`ifdef UART_TX_BUFFER_TIMEOUT_EN
    $display("[TB] frame timeout");
    doReset();
    applyStimulus(1'b1, 8'h77, 1'b0);
    waitDataUpdate("to_wait");
    hiCnt = 0;
    while (dataUpdate && hiCnt < 200) begin
      hiCnt++;
      applyStimulus(1'b0, 8'h00, 1'b0);
    end
    checkOutput("to_len", 32'(hiCnt), 32'(TIMEOUT));
    checkOutput("to_err", 32'(timeoutErr), 32'd1);
`else
    hiCnt = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
